// File: rtl/vcompress_pack_if.sv
// rtl/vcompress_pack_if.sv - source/result stream bundle for vcompress_pack
interface vcompress_pack_if #(
   parameter int REQ_DATA_WIDTH  = 64,
   parameter int RESP_DATA_WIDTH = 64,
   parameter int REQ_ADDR_WIDTH  = 32,
   parameter int SEW_WIDTH       = 2,
   parameter int MASK_WIDTH      = 8
);
   logic                       in_valid;
   logic                       in_ready;
   logic                       in_start;
   logic                       in_end;
   logic [SEW_WIDTH-1:0]       in_sew;
   logic [REQ_ADDR_WIDTH-1:0]  in_addr;
   logic [REQ_DATA_WIDTH-1:0]  in_vec0;
   logic [MASK_WIDTH-1:0]      in_mask;
   logic                       out_valid;
   logic [RESP_DATA_WIDTH-1:0] out_vec;
   logic [7:0]                 out_be;
   logic [REQ_ADDR_WIDTH-1:0]  out_addr;
   logic                       out_last;

   modport slave (
      input  in_valid, in_start, in_end, in_sew, in_addr, in_vec0, in_mask,
      output in_ready, out_valid, out_vec, out_be, out_addr, out_last
   );

   modport master (
      output in_valid, in_start, in_end, in_sew, in_addr, in_vec0, in_mask,
      input  in_ready, out_valid, out_vec, out_be, out_addr, out_last
   );
endinterface

// File: rtl/vcompress_pack.sv
// rtl/vcompress_pack.sv - mask-driven vector compress, dense result beats (optional VCOMPRESS_ZERO_FILL_EN)
module vcompress_pack #(
   parameter int REQ_DATA_WIDTH  = 64,
   parameter int RESP_DATA_WIDTH = 64,
   parameter int REQ_ADDR_WIDTH  = 32,
   parameter int SEW_WIDTH       = 2,
   parameter int MASK_WIDTH      = 8
) (
   input logic             clk,
   input logic             rst,
   vcompress_pack_if.slave bus
);
   localparam logic [REQ_ADDR_WIDTH-1:0] ADDR_STEP = REQ_ADDR_WIDTH'(8);

   // accept side
   logic                       in_ready_q;
   logic                       open_q;
   logic [SEW_WIDTH-1:0]       isew_q;
   logic                       acc;
   logic                       take;

   // S0: registered source beat
   logic                       s0_valid_q;
   logic                       s0_start_q;
   logic                       s0_end_q;
   logic [SEW_WIDTH-1:0]       s0_sew_q;
   logic [REQ_ADDR_WIDTH-1:0]  s0_addr_q;
   logic [REQ_DATA_WIDTH-1:0]  s0_vec_q;
   logic [MASK_WIDTH-1:0]      s0_mask_q;

   // S1: packed elements
   logic [REQ_DATA_WIDTH-1:0]  pk_d;
   logic [3:0]                 pk_cnt_d;
   logic [3:0]                 eb0;
   logic [3:0]                 epb0;
   logic [2:0]                 di;
   logic [2:0]                 si;
   logic                       s1_valid_q;
   logic                       s1_start_q;
   logic                       s1_end_q;
   logic [SEW_WIDTH-1:0]       s1_sew_q;
   logic [REQ_ADDR_WIDTH-1:0]  s1_addr_q;
   logic [REQ_DATA_WIDTH-1:0]  s1_pk_q;
   logic [3:0]                 s1_cnt_q;

   // S2: residual state and combine
   logic [63:0]                res_q, res_d;
   logic [2:0]                 res_cnt_q, res_cnt_d;
   logic [REQ_ADDR_WIDTH-1:0]  addr_q, addr_d;
   logic [SEW_WIDTH-1:0]       sew_q, sew_d;
   logic                       flush_q, flush_d;
   logic [63:0]                rb;
   logic [2:0]                 rc;
   logic [REQ_ADDR_WIDTH-1:0]  ab;
   logic [3:0]                 eb1;
   logic [3:0]                 epb1;
   logic [2:0]                 sh;
   logic [2:0]                 pb;
   logic [127:0]               comb;
   logic [3:0]                 tot;
   logic                       full;

   // result registers
   logic                       out_valid_q, ov_d;
   logic [RESP_DATA_WIDTH-1:0] out_vec_q, vec_d, vec_f;
   logic [7:0]                 out_be_q, be_d;
   logic [REQ_ADDR_WIDTH-1:0]  out_addr_q, oa_d;
   logic                       out_last_q, last_d;

   assign acc  = bus.in_valid && in_ready_q;
   assign take = acc && (bus.in_start || open_q);

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_vec   = out_vec_q;
   assign bus.out_be    = out_be_q;
   assign bus.out_addr  = out_addr_q;
   assign bus.out_last  = out_last_q;

   // Accept beats, track the open instruction and the one-cycle flush bubble, register S0
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         in_ready_q <= 1'b1;
         open_q     <= 1'b0;
         isew_q     <= '0;
         s0_valid_q <= 1'b0;
         s0_start_q <= 1'b0;
         s0_end_q   <= 1'b0;
         s0_sew_q   <= '0;
         s0_addr_q  <= '0;
         s0_vec_q   <= '0;
         s0_mask_q  <= '0;
      end else begin
         in_ready_q <= !(acc && bus.in_end);
         s0_valid_q <= take;
         if (acc) begin
            if (bus.in_start) begin
               open_q <= !bus.in_end;
               isew_q <= bus.in_sew;
            end else if (bus.in_end) begin
               open_q <= 1'b0;
            end
         end
         if (take) begin
            s0_start_q <= bus.in_start;
            s0_end_q   <= bus.in_end;
            s0_sew_q   <= bus.in_start ? bus.in_sew : isew_q;
            s0_addr_q  <= bus.in_addr;
            s0_vec_q   <= bus.in_vec0;
            s0_mask_q  <= bus.in_mask;
         end
      end
   end

   // Gather the selected elements of the S0 beat toward element 0, preserving order
   always_comb begin
      pk_d     = '0;
      pk_cnt_d = '0;
      di       = '0;
      si       = '0;
      eb0      = 4'd1 << s0_sew_q;
      epb0     = 4'd8 >> s0_sew_q;
      for (int i = 0; i < 8; i++) begin
         if ((4'(i) < epb0) && s0_mask_q[i]) begin
            for (int b = 0; b < 8; b++) begin
               if (4'(b) < eb0) begin
                  di = 3'(pk_cnt_d * eb0 + 4'(b));
                  si = 3'(4'(i) * eb0 + 4'(b));
                  pk_d[{di, 3'b000} +: 8] = s0_vec_q[{si, 3'b000} +: 8];
               end
            end
            pk_cnt_d = pk_cnt_d + 4'd1;
         end
      end
   end

   // Register S1: packed data and element count travel with the beat's control bits
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_valid_q <= 1'b0;
         s1_start_q <= 1'b0;
         s1_end_q   <= 1'b0;
         s1_sew_q   <= '0;
         s1_addr_q  <= '0;
         s1_pk_q    <= '0;
         s1_cnt_q   <= '0;
      end else begin
         s1_valid_q <= s0_valid_q;
         if (s0_valid_q) begin
            s1_start_q <= s0_start_q;
            s1_end_q   <= s0_end_q;
            s1_sew_q   <= s0_sew_q;
            s1_addr_q  <= s0_addr_q;
            s1_pk_q    <= pk_d;
            s1_cnt_q   <= pk_cnt_d;
         end
      end
   end

   // Combine residual with packed elements; decide full beat, partial close, empty close or flush
   always_comb begin
      rb = res_q;
      rc = res_cnt_q;
      ab = addr_q;
      if (s1_start_q) begin
         rb = '0;
         rc = '0;
         ab = s1_addr_q;
      end
      eb1  = 4'd1 << s1_sew_q;
      epb1 = 4'd8 >> s1_sew_q;
      sh   = 3'(4'(rc) * eb1);
      comb = {64'b0, rb} | ({64'b0, s1_pk_q} << {sh, 3'b000});
      tot  = 4'(rc) + s1_cnt_q;
      full = tot >= epb1;
      pb   = '0;

      res_d     = res_q;
      res_cnt_d = res_cnt_q;
      addr_d    = addr_q;
      sew_d     = sew_q;
      flush_d   = 1'b0;
      ov_d      = 1'b0;
      vec_d     = out_vec_q;
      be_d      = out_be_q;
      oa_d      = out_addr_q;
      last_d    = 1'b0;

      if (flush_q) begin
         // residual left over by a full end beat goes out one cycle later
         pb        = 3'(4'(res_cnt_q) * (4'd1 << sew_q));
         ov_d      = 1'b1;
         vec_d     = res_q;
         be_d      = (8'h01 << pb) - 8'h01;
         oa_d      = addr_q;
         last_d    = 1'b1;
         res_d     = '0;
         res_cnt_d = '0;
         addr_d    = addr_q + ADDR_STEP;
      end else if (s1_valid_q) begin
         sew_d = s1_sew_q;
         if (full) begin
            ov_d      = 1'b1;
            vec_d     = comb[63:0];
            be_d      = 8'hFF;
            oa_d      = ab;
            addr_d    = ab + ADDR_STEP;
            res_d     = comb[127:64];
            res_cnt_d = 3'(tot - epb1);
            if (s1_end_q) begin
               if (res_cnt_d != 3'd0) flush_d = 1'b1;
               else                   last_d  = 1'b1;
            end
         end else begin
            res_d     = comb[63:0];
            res_cnt_d = 3'(tot);
            addr_d    = ab;
            if (s1_end_q) begin
               // partial close; an empty instruction closes with be=0
               pb        = 3'(tot * eb1);
               ov_d      = 1'b1;
               vec_d     = comb[63:0];
               be_d      = (8'h01 << pb) - 8'h01;
               oa_d      = ab;
               last_d    = 1'b1;
               res_d     = '0;
               res_cnt_d = '0;
               addr_d    = ab + ADDR_STEP;
            end
         end
      end
   end

   // Optionally clear result bytes that carry no enable
   always_comb begin
      vec_f = vec_d;
`ifdef VCOMPRESS_ZERO_FILL_EN
      for (int k = 0; k < 8; k++) begin
         if (!be_d[k]) vec_f[k*8 +: 8] = 8'h00;
      end
`endif
   end

   // Register S2 state and the result beat
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         res_q       <= '0;
         res_cnt_q   <= '0;
         addr_q      <= '0;
         sew_q       <= '0;
         flush_q     <= 1'b0;
         out_valid_q <= 1'b0;
         out_vec_q   <= '0;
         out_be_q    <= '0;
         out_addr_q  <= '0;
         out_last_q  <= 1'b0;
      end else begin
         res_q       <= res_d;
         res_cnt_q   <= res_cnt_d;
         addr_q      <= addr_d;
         sew_q       <= sew_d;
         flush_q     <= flush_d;
         out_valid_q <= ov_d;
         out_vec_q   <= vec_f;
         out_be_q    <= be_d;
         out_addr_q  <= oa_d;
         out_last_q  <= last_d;
      end
   end
endmodule

// File: doc/vcompress_pack.md
# vcompress_pack

Pipelined vector-compress unit for the vALU. Takes a stream of REQ_DATA_WIDTH-bit source beats with a per-element mask and emits only the mask-selected elements, packed contiguously into dense result beats with destination addresses. This is the inverse of the mask-select merge path. The merge path scatters by mask into a full-width beat; this block gathers by mask into a dense stream. Downstream is the vector register-file writeback port.

## Interface
- REQ_DATA_WIDTH, 64, source beat width (8 byte lanes)
- RESP_DATA_WIDTH, 64, result beat width (equals REQ_DATA_WIDTH)
- REQ_ADDR_WIDTH, 32, destination address width
- SEW_WIDTH, 2, element-width code width
- MASK_WIDTH, 8, mask bits per beat
- clk  in  1  sole clock, rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  source beat present
- in_ready  out  1  beat accepted when in_valid && in_ready
- in_start  in  1  first beat of an instruction
- in_end  in  1  last beat of an instruction (may coincide with in_start)
- in_sew  in  SEW_WIDTH  element width: 0=8b, 1=16b, 2=32b, 3=64b
- in_addr  in  REQ_ADDR_WIDTH  destination base address, used on in_start
- in_vec0  in  REQ_DATA_WIDTH  source elements, element i at bits [i*E+E-1:i*E]
- in_mask  in  MASK_WIDTH  bit i selects element i; only bits [EPB-1:0] are used, where EPB = 8>>sew
- out_valid  out  1  result beat valid (single-cycle pulse per beat)
- out_vec  out  RESP_DATA_WIDTH  packed result
- out_be  out  8  byte enables of out_vec
- out_addr  out  REQ_ADDR_WIDTH  destination of this beat
- out_last  out  1  final result beat of the instruction

## Operation
- in_sew and the base address are latched on an accepted in_start beat. in_sew is ignored on every other beat.
- Stage S0: registers the accepted beat.
- Stage S1: packs the selected elements of the beat toward element 0, keeping their order. Produces cnt = popcount(mask[EPB-1:0]), range 0..EPB.
- Stage S2 (combine): concatenates the residual buffer (res_cnt < EPB elements) with the packed elements at offset res_cnt.
  - If res_cnt + cnt >= EPB: emit the low EPB elements as a full beat with out_be=0xFF. The remainder becomes the new residual, res_cnt = res_cnt + cnt - EPB.
  - Otherwise: accumulate, with no output.
- End of instruction, when the in_end beat is in S2:
  - If a full beat is produced and a residual remains, the full beat is emitted this cycle. The residual is flushed in the next cycle as a partial beat with out_last=1.
  - If no full beat is produced and res_cnt > 0, the partial beat is emitted this cycle with out_last=1.
  - If a full beat is produced and no residual remains, that beat carries out_last=1.
  - If the instruction selected zero elements in total, one beat is emitted with out_valid=1, out_be=0, out_last=1, so that writeback retires.
- Partial beat: out_be has its low res_cnt*(1<<sew) bits set.
- out_addr starts at the latched base and increments by 8 after each emitted beat, wrapping modulo 2^REQ_ADDR_WIDTH.
- A start beat clears res_cnt and the residual buffer.
- Flush bubble: in_ready is low for exactly the one cycle after an in_end beat is accepted. It is high at all other times. in_valid is ignored while in_ready is low. This reserves the S2 flush slot so that the next instruction cannot collide with it.

## Timing
- Latency: for an input beat sampled at edge N, the result it completes is registered at edge N+2. A flush beat is registered at edge N+3.
- Throughput: one beat per cycle within an instruction. Instruction-to-instruction spacing is at least one idle cycle.
- out_valid and out_last are held high for one cycle per beat. There is no output backpressure.
- Reset values:
  - out_valid=0, out_vec=0, out_be=0, out_addr=0, out_last=0, in_ready=1.
  - All pipeline valid bits and res_cnt are 0.
- Assertion of rst takes effect immediately, without waiting for a clock edge. Any instruction in progress is discarded and no partial beat is emitted. The first accepted beat after reset must carry in_start.
- A beat arriving without in_start while no instruction is open is dropped.

## Configuration
- VCOMPRESS_ZERO_FILL_EN
  - Defined: out_vec bytes whose out_be bit is 0 are forced to 0, including the zero-element beat.
  - Undefined: those bytes are don't-care, holding leftover residual contents. Checkers compare only the enabled bytes.

## Test plan
- sew=0, single beat with start+end, mask 0xFF, vec 0x0706050403020100, addr 0x1000 -> 2 cycles later one beat: vec 0x0706050403020100, be 0xFF, addr 0x1000, last=1.
- sew=0, single beat, mask 0xA5, same vec -> one beat with out_vec[31:0]=0x07050200, be 0x0F, last=1. With ZERO_FILL_EN, out_vec[63:32]=0.
- sew=0, two beats: mask 0x0F on vec 0x..03020100, then mask 0xF0 on vec 0x1716151413121110 with in_end -> one beat 0x1716151403020100, be 0xFF, last=1, addr = base.
- sew=2, three beats with masks 0b11, 0b01, 0b11 (5 elements), base 0x2000:
  - Beats at 0x2000 and 0x2008 with be 0xFF.
  - A flush beat at 0x2010 with be 0x0F and last=1, one cycle after the second beat.
  - in_ready low for exactly one cycle after the in_end beat is accepted.
- sew=1, single beat, mask 0x00 -> one beat with out_valid=1, be 0x00, last=1.
- rst driven low mid-instruction, with a residual held -> all outputs 0 before the next edge. After rst returns high, a new single-beat instruction produces correct output, with no stale residual.
